// File: rtl/serv_dbus_pkg.sv
// Shared constants and state encodings for the SERV bit-serial data-bus controller.
package serv_dbus_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t SHIFT_IN  = 2'd1;
    localparam state_t REQ       = 2'd2;
    localparam state_t SHIFT_OUT = 2'd3;

endpackage

// File: rtl/serv_dbus_align.sv
// Combinational lane logic: byte enables, store replication, load shift/extend and
// the misalignment flag, all derived from access size, byte offset and signedness.
module serv_dbus_align
    import serv_dbus_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      lsb_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      sel_o,
    output logic [XLEN-1:0] dat_o,
    output logic [XLEN-1:0] load_o,
    output logic            misalign_o
);

    logic            is_byte;
    logic            is_half;
    logic [1:0]      lsb_eff;
    logic [XLEN-1:0] rshift;

    assign is_byte = (size_i == SZ_BYTE);
    assign is_half = (size_i == SZ_HALF);

    // Size 2'b11 falls through every byte/half test and behaves as a word.
    assign misalign_o = is_half ? lsb_i[0] : (!is_byte && (lsb_i != 2'b00));

    // Offset bits below the access granule are dropped; this only matters when
    // misaligned accesses are allowed to proceed.
    assign lsb_eff = is_byte ? lsb_i : (is_half ? {lsb_i[1], 1'b0} : 2'b00);
    assign rshift  = rdata_i >> {lsb_eff, 3'b000};

    always_comb begin
        sel_o  = 4'b1111;
        dat_o  = wdata_i;
        load_o = rshift;
        if (is_byte) begin
            sel_o  = 4'b0001 << lsb_eff;
            dat_o  = {4{wdata_i[7:0]}};
            load_o = {{24{signed_i & rshift[7]}}, rshift[7:0]};
        end else if (is_half) begin
            sel_o  = lsb_eff[1] ? 4'b1100 : 4'b0011;
            dat_o  = {2{wdata_i[15:0]}};
            load_o = {{16{signed_i & rshift[15]}}, rshift[15:0]};
        end
    end

endmodule

// File: rtl/serv_dbus_ctrl.sv
// Bit-serial data-bus controller: deserialises store data, runs one bus transaction
// per memory instruction and serialises aligned/extended load data back out LSB first.
module serv_dbus_ctrl
    import serv_dbus_pkg::*;
#(
    parameter int unsigned W             = 1,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_we,
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    input  logic [1:0]      i_lsb,
    input  logic [XLEN-1:0] i_adr,
    input  logic [W-1:0]    i_rs2,
    output logic [W-1:0]    o_rd,
    output logic            o_rd_valid,
    output logic [XLEN-1:0] o_dbus_adr,
    output logic [XLEN-1:0] o_dbus_dat,
    output logic [3:0]      o_dbus_sel,
    output logic            o_dbus_we,
    output logic            o_dbus_cyc,
    input  logic [XLEN-1:0] i_dbus_rdt,
    input  logic            i_dbus_ack,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_misalign
);

    if (W != 1) begin : g_w_check
        $error("serv_dbus_ctrl: only W=1 is supported");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  shreg_q, shreg_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             signed_q, signed_d;
    logic [1:0]       lsb_q, lsb_d;
    logic [XLEN-1:2]  adr_q, adr_d;
    logic             done_q, done_d;
    logic             misalign_q, misalign_d;

    logic             in_idle;
    logic             in_req;
    logic [1:0]       al_size;
    logic [1:0]       al_lsb;
    logic [3:0]       al_sel;
    logic [XLEN-1:0]  al_dat;
    logic [XLEN-1:0]  al_load;
    logic             al_misalign;
    logic             unused_adr;

    assign in_idle    = (state_q == IDLE);
    assign in_req     = (state_q == REQ);
    assign unused_adr = ^i_adr[1:0];

    // While idle the aligner judges the incoming request; afterwards the latched one.
    assign al_size = in_idle ? i_size : size_q;
    assign al_lsb  = in_idle ? i_lsb  : lsb_q;

    serv_dbus_align u_align (
        .size_i     (al_size),
        .lsb_i      (al_lsb),
        .signed_i   (signed_q),
        .wdata_i    (shreg_q),
        .rdata_i    (i_dbus_rdt),
        .sel_o      (al_sel),
        .dat_o      (al_dat),
        .load_o     (al_load),
        .misalign_o (al_misalign)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        lsb_d      = lsb_q;
        adr_d      = adr_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    we_d     = i_we;
                    size_d   = i_size;
                    signed_d = i_signed;
                    lsb_d    = i_lsb;
                    adr_d    = i_adr[XLEN-1:2];
                    cnt_d    = '0;
                    if (MISALIGN_TRAP && al_misalign) begin
                        misalign_d = 1'b1;
                    end else if (i_we) begin
                        state_d = SHIFT_IN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            SHIFT_IN: begin
                shreg_d = {i_rs2[0], shreg_q[XLEN-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_dbus_ack) begin
                    if (we_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shreg_d = al_load;
                        state_d = SHIFT_OUT;
                    end
                end
            end
            SHIFT_OUT: begin
                shreg_d = {1'b0, shreg_q[XLEN-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            lsb_q      <= 2'b00;
            adr_q      <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            we_q       <= we_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            lsb_q      <= lsb_d;
            adr_q      <= adr_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_rd_valid = (state_q == SHIFT_OUT);
    assign o_rd       = o_rd_valid & shreg_q[0];
    assign o_dbus_adr = {adr_q, 2'b00};
    assign o_dbus_cyc = in_req;
    assign o_dbus_we  = in_req & we_q;
    assign o_dbus_sel = in_req ? al_sel : 4'b0000;
    assign o_dbus_dat = in_req ? al_dat : '0;
    assign o_busy     = !in_idle;
    assign o_done     = done_q;
    assign o_misalign = misalign_q;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Self-checking bench: a transaction-level model predicts every output each cycle,
// and directed tests pin the model with hand-computed literal values.
module tb_serv_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn = 1'b0;
    logic [1:0]  lsb = 2'b00;
    logic [31:0] adr = 32'h0;
    logic [0:0]  rs2 = 1'b0;
    logic [31:0] rdt = 32'h0;
    logic        ack = 1'b0;

    logic [0:0]  o_rd;
    logic        o_rd_valid, o_dbus_we, o_dbus_cyc, o_busy, o_done, o_misalign;
    logic [31:0] o_dbus_adr, o_dbus_dat;
    logic [3:0]  o_dbus_sel;

    logic [0:0]  nt_rd;
    logic        nt_rd_valid, nt_we, nt_cyc, nt_busy, nt_done, nt_misalign;
    logic [31:0] nt_adr, nt_dat;
    logic [3:0]  nt_sel;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serv_dbus_ctrl #(.W(1), .MISALIGN_TRAP(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_we(we), .i_size(size),
        .i_signed(sgn), .i_lsb(lsb), .i_adr(adr), .i_rs2(rs2), .o_rd(o_rd),
        .o_rd_valid(o_rd_valid), .o_dbus_adr(o_dbus_adr), .o_dbus_dat(o_dbus_dat),
        .o_dbus_sel(o_dbus_sel), .o_dbus_we(o_dbus_we), .o_dbus_cyc(o_dbus_cyc),
        .i_dbus_rdt(rdt), .i_dbus_ack(ack), .o_busy(o_busy), .o_done(o_done),
        .o_misalign(o_misalign)
    );

    serv_dbus_ctrl #(.W(1), .MISALIGN_TRAP(1'b0)) dut_nt (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_we(we), .i_size(size),
        .i_signed(sgn), .i_lsb(lsb), .i_adr(adr), .i_rs2(rs2), .o_rd(nt_rd),
        .o_rd_valid(nt_rd_valid), .o_dbus_adr(nt_adr), .o_dbus_dat(nt_dat),
        .o_dbus_sel(nt_sel), .o_dbus_we(nt_we), .o_dbus_cyc(nt_cyc),
        .i_dbus_rdt(rdt), .i_dbus_ack(ack), .o_busy(nt_busy), .o_done(nt_done),
        .o_misalign(nt_misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (trapping instance) ----------------
    int          m_shift_left = 0;
    bit          m_req = 1'b0;
    bit          m_we = 1'b0;
    logic [1:0]  m_size = 2'b00;
    logic [1:0]  m_lsb = 2'b00;
    bit          m_sgn = 1'b0;
    logic [31:0] m_adr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_v = 32'h0;
    bit          m_rdq[$];
    bit          m_done = 1'b0;
    bit          m_mis = 1'b0;

    function automatic logic [31:0] m_ext(input logic [1:0] sz, input logic [1:0] l,
                                          input bit s, input logic [31:0] r);
        logic [31:0] v;
        v = r >> (int'(l) * 8);
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [1:0] l);
        if (sz == 2'b00) return 4'b0001 << l;
        if (sz == 2'b01) return l[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_dat(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [1:0] l);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return l[0];
        return l != 2'b00;
    endfunction

    function automatic bit m_busy();
        return (m_shift_left != 0) || m_req || (m_rdq.size() != 0);
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        m_mis  = 1'b0;
        if (rst) begin
            m_shift_left = 0;
            m_req = 1'b0;
            m_rdq.delete();
        end else if (m_rdq.size() != 0) begin
            void'(m_rdq.pop_front());
            if (m_rdq.size() == 0) m_done = 1'b1;
        end else if (m_shift_left != 0) begin
            m_wdata[32 - m_shift_left] = rs2[0];
            m_shift_left--;
            if (m_shift_left == 0) m_req = 1'b1;
        end else if (m_req) begin
            if (ack) begin
                m_req = 1'b0;
                if (m_we) begin
                    m_done = 1'b1;
                end else begin
                    m_v = m_ext(m_size, m_lsb, m_sgn, rdt);
                    for (int i = 0; i < 32; i++) m_rdq.push_back(m_v[i]);
                end
            end
        end else if (start) begin
            m_we = we; m_size = size; m_lsb = lsb; m_sgn = sgn; m_adr = adr;
            if (m_misaligned(size, lsb)) m_mis = 1'b1;
            else if (we) m_shift_left = 32;
            else m_req = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(o_busy), 32'(m_busy()));
            check("done", 32'(o_done), 32'(m_done));
            check("misalign", 32'(o_misalign), 32'(m_mis));
            check("cyc", 32'(o_dbus_cyc), 32'(m_req));
            check("rd_valid", 32'(o_rd_valid), 32'(m_rdq.size() != 0));
            if (m_rdq.size() != 0) check("rd_bit", 32'(o_rd), 32'(m_rdq[0]));
            if (m_req) begin
                check("adr", o_dbus_adr, m_adr & 32'hFFFF_FFFC);
                check("sel", 32'(o_dbus_sel), 32'(m_sel(m_size, m_lsb)));
                check("we", 32'(o_dbus_we), 32'(m_we));
                if (m_we) check("dat", o_dbus_dat, m_dat(m_size, m_wdata));
            end else begin
                check("we_off", 32'(o_dbus_we), 32'h0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_store(input logic [1:0] sz, input logic [1:0] l, input logic [31:0] a,
                            input logic [31:0] d, input int dly, input logic [31:0] x_dat,
                            input logic [3:0] x_sel, input logic [31:0] x_adr);
        int lat;
        start = 1'b1; we = 1'b1; size = sz; lsb = l; adr = a; sgn = 1'b0;
        step();
        start = 1'b0;
        lat = 1;
        for (int i = 0; i < 32; i++) begin
            rs2[0] = d[i];
            step();
            lat++;
        end
        while (!o_dbus_cyc && lat < 100) begin
            step();
            lat++;
        end
        check("st_latency", lat, 33);
        check("st_dat", o_dbus_dat, x_dat);
        check("st_sel", 32'(o_dbus_sel), 32'(x_sel));
        check("st_adr", o_dbus_adr, x_adr);
        check("st_we", 32'(o_dbus_we), 32'h1);
        repeat (dly) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("st_done", 32'(o_done), 32'h1);
        step();
    endtask

    // dly == 0 holds ack high together with start; otherwise ack arrives dly cycles later.
    task automatic do_load(input logic [1:0] sz, input logic [1:0] l, input bit s,
                           input logic [31:0] a, input logic [31:0] r, input int dly,
                           input bit poke, input logic [31:0] x_val);
        logic [31:0] got;
        start = 1'b1; we = 1'b0; size = sz; lsb = l; sgn = s; adr = a; rdt = r;
        if (dly == 0) ack = 1'b1;
        step();
        start = 1'b0;
        check("ld_cyc_lat", 32'(o_dbus_cyc), 32'h1);
        if (dly != 0) begin
            repeat (dly - 1) step();
            ack = 1'b1;
        end
        step();
        ack = 1'b0;
        got = 32'h0;
        for (int i = 0; i < 32; i++) begin
            got[i] = o_rd[0];
            if (poke && i == 5) begin
                start = 1'b1; we = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check("ld_value", got, x_val);
        check("ld_done", 32'(o_done), 32'h1);
        step();
    endtask

    initial begin
        logic [31:0] got;
        step();
        chk_en = 1'b1;
        check("rst_flags", {25'h0, o_busy, o_done, o_misalign, o_dbus_cyc, o_dbus_we,
                            o_rd_valid, o_rd[0]}, 32'h0);
        check("rst_sel", 32'(o_dbus_sel), 32'h0);
        check("rst_adr", o_dbus_adr, 32'h0);
        check("rst_dat", o_dbus_dat, 32'h0);
        step();
        rst = 1'b0;
        step();

        do_store(2'b10, 2'd0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'b1111,
                 32'h0000_0100);
        do_store(2'b00, 2'd2, 32'h0000_0102, 32'h0000_00A5, 0, 32'hA5A5_A5A5, 4'b0100,
                 32'h0000_0100);
        do_store(2'b01, 2'd2, 32'h0000_040A, 32'h1234_BEEF, 1, 32'hBEEF_BEEF, 4'b1100,
                 32'h0000_0408);

        do_load(2'b00, 2'd3, 1'b1, 32'h0000_0103, 32'h8012_3456, 4, 1'b1, 32'hFFFF_FF80);
        do_load(2'b01, 2'd2, 1'b0, 32'h0000_0102, 32'h8012_3456, 1, 1'b0, 32'h0000_8012);
        do_load(2'b01, 2'd0, 1'b1, 32'h0000_0200, 32'h0000_9ABC, 2, 1'b0, 32'hFFFF_9ABC);
        do_load(2'b00, 2'd1, 1'b0, 32'h0000_0201, 32'h8012_3456, 3, 1'b0, 32'h0000_0034);
        do_load(2'b11, 2'd0, 1'b1, 32'h0000_0204, 32'h8012_3456, 0, 1'b0, 32'h8012_3456);

        // Ack while idle must be ignored.
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check("idle_ack_busy", 32'(o_busy), 32'h0);
        check("idle_ack_done", 32'(o_done), 32'h0);

        // Misaligned word: trap instance pulses, non-trap instance proceeds aligned.
        start = 1'b1; we = 1'b0; size = 2'b10; lsb = 2'd1; sgn = 1'b0;
        adr = 32'h0000_0203; rdt = 32'h8012_3456;
        step();
        start = 1'b0;
        check("mis_pulse", 32'(o_misalign), 32'h1);
        check("mis_no_cyc", 32'(o_dbus_cyc), 32'h0);
        check("nt_cyc", 32'(nt_cyc), 32'h1);
        check("nt_adr", nt_adr, 32'h0000_0200);
        check("nt_sel", 32'(nt_sel), 32'hF);
        check("nt_no_mis", 32'(nt_misalign), 32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("mis_single", 32'(o_misalign), 32'h0);
        got = 32'h0;
        for (int i = 0; i < 32; i++) begin
            got[i] = nt_rd[0];
            step();
        end
        check("nt_value", got, 32'h8012_3456);
        check("nt_done", 32'(nt_done), 32'h1);
        step();

        // Reset abort while waiting for a late ack.
        start = 1'b1; we = 1'b0; size = 2'b10; lsb = 2'd0; adr = 32'h0000_0300;
        rdt = 32'h1111_2222;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_cyc", 32'(o_dbus_cyc), 32'h0);
        check("abort_busy", 32'(o_busy), 32'h0);
        repeat (6) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("abort_no_done", 32'(o_done), 32'h0);
        step();
        do_load(2'b10, 2'd0, 1'b0, 32'h0000_0300, 32'h1111_2222, 2, 1'b0, 32'h1111_2222);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
